dcdl_code_ramp: RTL and testbench

- Synchronous controller that drives the thermometer enables of the tunable inverter delay chain in the analog-core CPU model.
- Takes a binary target delay code over a valid/ready handshake.
- Walks the chain enable one tap per update period so the delay line never jumps multiple taps at once (glitch-free retuning).
- Sits directly upstream of the inverter-chain cells; its thermometer output is their per-tap enable.

---
 rtl/dcdl_pkg.sv | 23 ++
 rtl/bin2thm.sv | 19 +
 rtl/dcdl_code_ramp.sv | 122 ++++++++++++
 tb/tb_dcdl_code_ramp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcdl_pkg.sv
// dcdl_pkg: shared types, default sizing and helpers for the delay-line controllers.
//   ramp_state_t  - ramp controller state encoding
//   N_TAP_DEF     - default number of tunable inverter taps
//   CW_DEF        - default code width (2**CW_DEF > N_TAP_DEF)
//   STEP_DIV_DEF  - default clock cycles between one-tap steps
//   clamp_code()  - limits a requested code to the number of physical taps
package dcdl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ramp_state_t;

    localparam int unsigned N_TAP_DEF    = 31;
    localparam int unsigned CW_DEF       = 5;
    localparam int unsigned STEP_DIV_DEF = 4;

    function automatic int unsigned clamp_code(input int unsigned code,
                                               input int unsigned n_tap);
        return (code > n_tap) ? n_tap : code;
    endfunction

endpackage

// File: rtl/bin2thm.sv
// bin2thm: combinational binary-to-thermometer converter.
//   code [CW-1:0]    binary tap count
//   thm  [N_TAP-1:0] thm[i] = (i < code)
module bin2thm #(
    parameter int unsigned N_TAP = 31,
    parameter int unsigned CW    = 5
) (
    input  logic [CW-1:0]    code,
    output logic [N_TAP-1:0] thm
);

    always_comb begin
        thm = '0;
        for (int unsigned i = 0; i < N_TAP; i++) begin
            thm[i] = (i < 32'(code));
        end
    end

endmodule

// File: rtl/dcdl_code_ramp.sv
// dcdl_code_ramp: walks the inverter-chain thermometer enable toward a requested code,
// one tap every STEP_DIV cycles, so the delay line is retuned without multi-tap jumps.
//   clk        model clock, rising edge
//   rstb       asynchronous active-low reset
//   en         ramp enable; low freezes all state
//   code_in    target delay code (clamped to N_TAP)
//   code_valid target present
//   code_ready block can accept a target
//   thm_out    per-tap enables to the inverter chain
//   cur_code   code currently applied
//   busy       ramp in progress
//   done       one-cycle pulse with the final step (or after a no-op request)
module dcdl_code_ramp
    import dcdl_pkg::*;
#(
    parameter int unsigned N_TAP    = N_TAP_DEF,
    parameter int unsigned CW       = CW_DEF,
    parameter int unsigned STEP_DIV = STEP_DIV_DEF
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [CW-1:0]    code_in,
    input  logic             code_valid,
    output logic             code_ready,
    output logic [N_TAP-1:0] thm_out,
    output logic [CW-1:0]    cur_code,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_DIV - 1);

    ramp_state_t      state_q, state_d;
    logic [CW-1:0]    cur_q, cur_d;
    logic [CW-1:0]    tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [N_TAP-1:0] thm_q, thm_d;
    logic             armed_q;
    logic             handshake;

    // armed_q keeps ready low until the first clock edge after reset release.
    assign code_ready = armed_q && en && (state_q == IDLE);
    assign handshake  = code_valid && code_ready;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    tgt_d = CW'(clamp_code(32'(code_in), N_TAP));
                    if (tgt_d == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_RELOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Step happens on the same edge that sees the expired counter.
                    cur_d = (cur_q < tgt_q) ? cur_q + CW'(1) : cur_q - CW'(1);
                    if (cur_d == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = CNT_RELOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Thermometer is decoded from the next code so it registers alongside cur_code.
    bin2thm #(
        .N_TAP (N_TAP),
        .CW    (CW)
    ) u_bin2thm (
        .code (cur_d),
        .thm  (thm_d)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            cur_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            thm_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (en) begin
                state_q <= state_d;
                cur_q   <= cur_d;
                tgt_q   <= tgt_d;
                cnt_q   <= cnt_d;
                done_q  <= done_d;
                thm_q   <= thm_d;
            end else begin
                done_q  <= 1'b0;
            end
        end
    end

    assign thm_out  = thm_q;
    assign cur_code = cur_q;
    assign busy     = (state_q == WAIT);
    assign done     = done_q && en;

endmodule

// File: tb/tb_dcdl_code_ramp.sv
// Bench for dcdl_code_ramp with N_TAP=20, CW=5, STEP_DIV=4.
module tb_dcdl_code_ramp;

    localparam int unsigned N_TAP    = 20;
    localparam int unsigned CW       = 5;
    localparam int unsigned STEP_DIV = 4;

    logic             clk;
    logic             rstb;
    logic             en;
    logic [CW-1:0]    code_in;
    logic             code_valid;
    logic             code_ready;
    logic [N_TAP-1:0] thm_out;
    logic [CW-1:0]    cur_code;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    dcdl_code_ramp #(
        .N_TAP    (N_TAP),
        .CW       (CW),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .en         (en),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .thm_out    (thm_out),
        .cur_code   (cur_code),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0]    code;
        logic [CW-1:0]    exp_cur;
        logic [N_TAP-1:0] exp_thm;
        int               exp_done_k;
        int               exp_busy;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int t;
        for (t = 0; t < 50; t++) begin
            if (code_ready) break;
            @(negedge clk);
        end
        if (t == 50) check({name, "_ready_timeout"}, 32'(code_ready), 32'd1);
    endtask

    // Handshake, then observe every cycle; sample k is just after edge H+k.
    task automatic run_vec(input string name, input vec_t v);
        int             busy_n = 0;
        int             done_n = 0;
        int             done_k = -1;
        bit             bad_spacing = 0;
        bit             bad_bits = 0;
        bit             bad_thm = 0;
        bit             over = 0;
        logic [CW-1:0]  prev_cur;
        logic [N_TAP-1:0] prev_thm;
        int             diff;
        wait_ready(name);
        prev_cur   = cur_code;
        prev_thm   = thm_out;
        code_in    = v.code;
        code_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        code_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (cur_code != prev_cur) begin
                diff = int'(cur_code) - int'(prev_cur);
                if ((k % STEP_DIV) != 0 || k == 0 || (diff != 1 && diff != -1))
                    bad_spacing = 1'b1;
            end
            if ($countones(thm_out ^ prev_thm) > 1) bad_bits = 1'b1;
            if (32'(thm_out) != ((32'd1 << cur_code) - 32'd1)) bad_thm = 1'b1;
            if (cur_code > CW'(N_TAP)) over = 1'b1;
            prev_cur = cur_code;
            prev_thm = thm_out;
            if (done_k >= 0 && k >= done_k + 3) break;
            @(negedge clk);
        end
        check({name, "_cur"},      32'(cur_code), 32'(v.exp_cur));
        check({name, "_thm"},      32'(thm_out),  32'(v.exp_thm));
        check({name, "_done_k"},   32'(done_k),   32'(v.exp_done_k));
        check({name, "_done_n"},   32'(done_n),   32'd1);
        check({name, "_busy_n"},   32'(busy_n),   32'(v.exp_busy));
        check({name, "_shape"},    {28'd0, bad_spacing, bad_bits, bad_thm, over}, 32'd0);
    endtask

    initial begin
        int chg1;
        int chg2;
        int pdone_k;
        int pdone_n;
        bit bad_pause;
        logic [CW-1:0] prev;

        vecs[0] = '{code: 5'd5,  exp_cur: 5'd5,  exp_thm: 20'h0001F, exp_done_k: 20, exp_busy: 20};
        vecs[1] = '{code: 5'd2,  exp_cur: 5'd2,  exp_thm: 20'h00003, exp_done_k: 12, exp_busy: 12};
        vecs[2] = '{code: 5'd2,  exp_cur: 5'd2,  exp_thm: 20'h00003, exp_done_k: 0,  exp_busy: 0};
        vecs[3] = '{code: 5'd31, exp_cur: 5'd20, exp_thm: 20'hFFFFF, exp_done_k: 72, exp_busy: 72};
        vecs[4] = '{code: 5'd20, exp_cur: 5'd20, exp_thm: 20'hFFFFF, exp_done_k: 0,  exp_busy: 0};
        vecs[5] = '{code: 5'd0,  exp_cur: 5'd0,  exp_thm: 20'h00000, exp_done_k: 80, exp_busy: 80};
        vecs[6] = '{code: 5'd1,  exp_cur: 5'd1,  exp_thm: 20'h00001, exp_done_k: 4,  exp_busy: 4};

        rstb       = 1'b0;
        en         = 1'b1;
        code_in    = '0;
        code_valid = 1'b0;

        // Reset state, ready held low through clock edges during reset.
        repeat (2) @(negedge clk);
        check("rst_cur",   32'(cur_code),   32'd0);
        check("rst_thm",   32'(thm_out),    32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_ready", 32'(code_ready), 32'd0);
        rstb = 1'b1;
        #1;
        check("rel_ready_before_edge", 32'(code_ready), 32'd0);
        @(negedge clk);
        check("rel_ready_after_edge", 32'(code_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Pause: 1 -> 3 with en low across edges H+2..H+8.
        wait_ready("pause");
        code_in    = 5'd3;
        code_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        code_valid = 1'b0;
        chg1 = -1; chg2 = -1; pdone_k = -1; pdone_n = 0; bad_pause = 0;
        prev = cur_code;
        for (int k = 0; k < 25; k++) begin
            if (cur_code != prev) begin
                if (chg1 < 0) chg1 = k;
                else if (chg2 < 0) chg2 = k;
            end
            prev = cur_code;
            if (done) begin
                pdone_n++;
                if (pdone_k < 0) pdone_k = k;
            end
            if (k >= 2 && k <= 8) begin
                if (code_ready || done || !busy || cur_code != 5'd1 || thm_out != 20'h1)
                    bad_pause = 1'b1;
            end
            en = !(k >= 1 && k <= 7);
            @(negedge clk);
        end
        en = 1'b1;
        check("pause_frozen", 32'(bad_pause), 32'd0);
        check("pause_step1_k", 32'(chg1), 32'd11);
        check("pause_step2_k", 32'(chg2), 32'd15);
        check("pause_done_k",  32'(pdone_k), 32'd15);
        check("pause_done_n",  32'(pdone_n), 32'd1);
        check("pause_cur",     32'(cur_code), 32'd3);
        check("pause_thm",     32'(thm_out),  32'h7);

        // en low while idle blocks ready.
        en = 1'b0;
        #1;
        check("idle_en0_ready", 32'(code_ready), 32'd0);
        @(negedge clk);
        en = 1'b1;
        #1;
        check("idle_en1_ready", 32'(code_ready), 32'd1);

        // Asynchronous reset mid-ramp: 3 -> 10, reset after two steps.
        @(negedge clk);
        wait_ready("arst");
        code_in    = 5'd10;
        code_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        code_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("arst_pre_cur",  32'(cur_code), 32'd5);
        check("arst_pre_busy", 32'(busy),     32'd1);
        #2;
        rstb = 1'b0;
        #1;
        check("arst_cur",   32'(cur_code),   32'd0);
        check("arst_thm",   32'(thm_out),    32'd0);
        check("arst_busy",  32'(busy),       32'd0);
        check("arst_ready", 32'(code_ready), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        run_vec("post_rst", '{code: 5'd2, exp_cur: 5'd2, exp_thm: 20'h00003,
                              exp_done_k: 8, exp_busy: 8});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
